// File: rtl/vram_arbiter_if.sv
// Display-fetch, host-write and memory-side signals of the VRAM arbiter.
`timescale 1ns/1ps
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 9
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_base;
    logic              disp_busy;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              disp_last;
    logic              overrun;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  disp_req, disp_base, host_valid, host_addr, host_wdata, mem_rdata,
        output disp_busy, disp_rdata, disp_rvalid, disp_last, overrun, host_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output disp_req, disp_base, host_valid, host_addr, host_wdata, mem_rdata,
        input  disp_busy, disp_rdata, disp_rvalid, disp_last, overrun, host_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port pixel memory arbiter: strict-priority display read bursts,
// host writes fill idle cycles. All memory-side outputs are registered.
`timescale 1ns/1ps
module vram_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned BURST_LEN = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {StIdle, StDisp} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic              r_final;
    logic              r_busy;
    logic              r_rvalid;
    logic              r_last;
    logic              r_overrun;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_host_ready;

    // Host may only write while idle and no display request is pending
    always_comb begin
        w_host_ready = (r_state == StIdle) && !bus.disp_req;
    end

    // Arbitration FSM with registered memory and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_base      <= '0;
            r_count     <= '0;
            r_final     <= 1'b0;
            r_busy      <= 1'b0;
            r_rvalid    <= 1'b0;
            r_last      <= 1'b0;
            r_overrun   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Data returns one cycle after each issued read
            r_rvalid  <= r_mem_en && !r_mem_we;
            r_last    <= r_mem_en && !r_mem_we && r_final;
            r_mem_en  <= 1'b0;
            r_overrun <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.disp_req) begin
                        // First read of the burst issues straight away
                        r_state    <= StDisp;
                        r_base     <= bus.disp_base;
                        r_count    <= CNT_W'(1);
                        r_final    <= (BURST_LEN == 1);
                        r_busy     <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.disp_base;
                    end else if (bus.host_valid) begin
                        r_final     <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= bus.host_addr;
                        r_mem_wdata <= bus.host_wdata;
                    end
                end
                StDisp: begin
                    // Requests during a burst are dropped and flagged
                    r_overrun <= bus.disp_req;
                    if (r_count == LAST_CNT) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_final <= 1'b0;
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_base + ADDR_W'(r_count);
                        r_count    <= r_count + CNT_W'(1);
                        r_final    <= (r_count == PEN_CNT);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.host_ready  = w_host_ready;
    assign bus.disp_busy   = r_busy;
    assign bus.disp_rdata  = bus.mem_rdata;
    assign bus.disp_rvalid = r_rvalid;
    assign bus.disp_last   = r_last;
    assign bus.overrun     = r_overrun;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a 4-word burst.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int BL = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(9)) vif ();

    vram_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (9),
        .BURST_LEN(BL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is the low 9 address bits, one cycle later
    always @(posedge clk) begin
        if (vif.mem_en && !vif.mem_we) vif.mem_rdata <= vif.mem_addr[8:0];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        total++;
        if ({vif.disp_busy, vif.disp_rvalid, vif.disp_last, vif.overrun, vif.mem_en,
             vif.mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000", {vif.disp_busy, vif.disp_rvalid,
                     vif.disp_last, vif.overrun, vif.mem_en, vif.mem_we});
        end
        total++;
        if (vif.mem_addr !== 16'h0 || vif.mem_wdata !== 9'h0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", vif.mem_addr, vif.mem_wdata);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (vif.host_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", vif.host_ready);
        end
        // Reset asserted in the middle of a cycle with a write on the bus
        next_cycle();
        vif.host_valid = 1'b1;
        vif.host_addr  = 16'h0ABC;
        vif.host_wdata = 9'h155;
        next_cycle();
        vif.host_valid = 1'b0;
        #1;
        total++;
        if (vif.mem_en !== 1'b1 || vif.mem_addr !== 16'h0ABC) begin
            bad++;
            $display("FAIL pre_reset_write: got en=%b addr=%h want 1/0abc", vif.mem_en, vif.mem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vif.disp_busy, vif.disp_rvalid, vif.disp_last, vif.overrun, vif.mem_en,
             vif.mem_we} !== 6'b0 || vif.mem_addr !== 16'h0 || vif.mem_wdata !== 9'h0) begin
            bad++;
            $display("FAIL async_reset: got en=%b we=%b addr=%h wdata=%h want all 0",
                     vif.mem_en, vif.mem_we, vif.mem_addr, vif.mem_wdata);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++;
        if (vif.host_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b want 1", vif.host_ready);
        end
    endtask

    task automatic test_host_write();
        next_cycle();
        vif.host_valid = 1'b1;
        vif.host_addr  = 16'h0123;
        vif.host_wdata = 9'h1A5;
        #1;
        total++;
        if (vif.host_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_ready: got %b want 1", vif.host_ready);
        end
        next_cycle();
        vif.host_valid = 1'b0;
        #1;
        total++;
        if ({vif.mem_en, vif.mem_we} !== 2'b11 || vif.mem_addr !== 16'h0123 ||
            vif.mem_wdata !== 9'h1A5) begin
            bad++;
            $display("FAIL single_write: got en=%b we=%b addr=%h wdata=%h want 1/1/0123/1a5",
                     vif.mem_en, vif.mem_we, vif.mem_addr, vif.mem_wdata);
        end
        next_cycle();
        #1;
        total++;
        if (vif.mem_en !== 1'b0 || vif.mem_addr !== 16'h0123 || vif.mem_wdata !== 9'h1A5) begin
            bad++;
            $display("FAIL write_hold: got en=%b addr=%h wdata=%h want 0/0123/1a5",
                     vif.mem_en, vif.mem_addr, vif.mem_wdata);
        end
        for (int i = 0; i <= 3; i++) begin
            next_cycle();
            vif.host_valid = (i < 3);
            vif.host_addr  = 16'(16'h0300 + i);
            vif.host_wdata = 9'(9'h040 + i);
            #1;
            if (i >= 1) begin
                total++;
                if ({vif.mem_en, vif.mem_we} !== 2'b11 || vif.mem_addr !== 16'(16'h0300 + i - 1) ||
                    vif.mem_wdata !== 9'(9'h040 + i - 1)) begin
                    bad++;
                    $display("FAIL b2b_write%0d: got en=%b we=%b addr=%h wdata=%h want 1/1/%h/%h",
                             i - 1, vif.mem_en, vif.mem_we, vif.mem_addr, vif.mem_wdata,
                             16'(16'h0300 + i - 1), 9'(9'h040 + i - 1));
                end
            end
        end
        vif.host_valid = 1'b0;
        next_cycle();
        #1;
        total++;
        if (vif.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got en=%b want 0", vif.mem_en);
        end
    endtask

    // One burst from base; optionally a second disp_req in cycle k+again_at
    task automatic test_burst(input logic [15:0] base, input int again_at);
        logic [15:0] ea;
        logic [15:0] ed;
        logic [5:0]  exp_flags;
        logic [5:0]  got_flags;
        next_cycle();
        vif.disp_req  = 1'b1;
        vif.disp_base = base;
        #1;
        total++;
        if (vif.host_ready !== 1'b0) begin
            bad++;
            $display("FAIL burst_accept_ready: got %b want 0", vif.host_ready);
        end
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            vif.disp_req  = (c == again_at);
            vif.disp_base = 16'h0500;
            #1;
            ea = base + 16'(c - 1);
            ed = base + 16'(c - 2);
            // busy, rvalid, last, overrun, mem_en, host_ready
            exp_flags = {(c <= BL), (c >= 2 && c <= BL + 1), (c == BL + 1),
                         (again_at != 0 && c == again_at + 1), (c <= BL), (c > BL)};
            got_flags = {vif.disp_busy, vif.disp_rvalid, vif.disp_last, vif.overrun,
                         vif.mem_en, vif.host_ready};
            total++;
            if (got_flags !== exp_flags) begin
                bad++;
                $display("FAIL burst_%h_flags_c%0d: got %b want %b", base, c, got_flags, exp_flags);
            end
            if (c <= BL) begin
                total++;
                if (vif.mem_we !== 1'b0 || vif.mem_addr !== ea) begin
                    bad++;
                    $display("FAIL burst_%h_read_c%0d: got we=%b addr=%h want 0/%h",
                             base, c, vif.mem_we, vif.mem_addr, ea);
                end
            end
            if (c >= 2 && c <= BL + 1) begin
                total++;
                if (vif.disp_rdata !== ed[8:0]) begin
                    bad++;
                    $display("FAIL burst_%h_data_c%0d: got %h want %h",
                             base, c, vif.disp_rdata, ed[8:0]);
                end
            end
        end
        vif.disp_req = 1'b0;
    endtask

    task automatic test_priority();
        next_cycle();
        vif.disp_req   = 1'b1;
        vif.disp_base  = 16'h0040;
        vif.host_valid = 1'b1;
        vif.host_addr  = 16'h0200;
        vif.host_wdata = 9'h0FF;
        #1;
        total++;
        if (vif.host_ready !== 1'b0) begin
            bad++;
            $display("FAIL prio_ready_k: got %b want 0", vif.host_ready);
        end
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            vif.disp_req   = 1'b0;
            vif.host_valid = (c <= 5);
            #1;
            total++;
            if (vif.host_ready !== (c >= 5)) begin
                bad++;
                $display("FAIL prio_ready_c%0d: got %b want %b", c, vif.host_ready, (c >= 5));
            end
            total++;
            if (c <= 4) begin
                if ({vif.mem_en, vif.mem_we} !== 2'b10 || vif.mem_addr !== 16'(16'h0040 + c - 1)) begin
                    bad++;
                    $display("FAIL prio_read_c%0d: got en=%b we=%b addr=%h want 1/0/%h", c,
                             vif.mem_en, vif.mem_we, vif.mem_addr, 16'(16'h0040 + c - 1));
                end
            end else if (c == 6) begin
                if ({vif.mem_en, vif.mem_we} !== 2'b11 || vif.mem_addr !== 16'h0200 ||
                    vif.mem_wdata !== 9'h0FF) begin
                    bad++;
                    $display("FAIL prio_write: got en=%b we=%b addr=%h wdata=%h want 1/1/0200/0ff",
                             vif.mem_en, vif.mem_we, vif.mem_addr, vif.mem_wdata);
                end
            end else begin
                if (vif.mem_en !== 1'b0) begin
                    bad++;
                    $display("FAIL prio_idle_c%0d: got en=%b want 0", c, vif.mem_en);
                end
            end
        end
        vif.host_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        vif.disp_req  = 1'b1;
        vif.disp_base = 16'h0080;
        next_cycle();
        vif.disp_req = 1'b0;
        #1;
        total++;
        if (vif.mem_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_started: got en=%b want 1", vif.mem_en);
        end
        next_cycle();
        #1;
        total++;
        if (vif.disp_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_rvalid_before: got %b want 1", vif.disp_rvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vif.mem_en, vif.disp_rvalid, vif.disp_busy, vif.disp_last} !== 4'b0) begin
            bad++;
            $display("FAIL midrst_now: got %b want 0000",
                     {vif.mem_en, vif.disp_rvalid, vif.disp_busy, vif.disp_last});
        end
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            if (j == 1) rst_n = 1'b1;
            #1;
            total++;
            if (vif.mem_en !== 1'b0 || vif.disp_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after_c%0d: got en=%b rvalid=%b want 0/0",
                         j, vif.mem_en, vif.disp_rvalid);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b1;
        vif.disp_req   = 1'b0;
        vif.disp_base  = '0;
        vif.host_valid = 1'b0;
        vif.host_addr  = '0;
        vif.host_wdata = '0;
        test_reset();
        test_host_write();
        test_burst(16'h0010, 0);
        test_priority();
        test_burst(16'hFFFE, 2);
        test_reset_mid_burst();
        test_burst(16'h0123, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
